// File: rtl/key_arbiter.sv
// key_arbiter
//   Turns debounced key presses into a stream of single-key events, one
//   offered at a time over a valid/ready handshake. Presses that arrive while
//   the same key still has an unserved event are lost and flagged.
//
//   Optional feature (macro KEY_REPEAT_EN): per-key hold counters generate
//   auto-repeat events while a key stays pressed. The first repeat comes
//   REPEAT_DELAY cycles after the press, then one every REPEAT_PERIOD cycles.
//   Without the macro, only rising edges create events and the REPEAT_*
//   parameters are unused.
//
// Ports
//   clk        in   sole clock, everything on posedge
//   rst        in   synchronous, active-high reset
//   key_i[3:0] in   key levels, 1 = pressed, synchronous to clk
//   evt_valid  out  an event is offered (high exactly in OFFER)
//   evt_id[1:0]out  key the offered event belongs to (holds its value in IDLE)
//   evt_ready  in   consumer accepts the offered event
//   pending    out  per-key event-pending flags
//   overflow   out  sticky: a press was dropped, cleared only by rst
//
// Handshake: an event transfers on a posedge where evt_valid && evt_ready.
// While evt_valid is high and evt_ready is low, evt_id is held stable.
// evt_valid drops for at least one cycle after every transfer.
module key_arbiter #(
    parameter logic [23:0] REPEAT_DELAY  = 24'd1000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_i,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    input  logic       evt_ready,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] key_prev_q;
    logic [3:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;
    logic [1:0] evt_id_q, evt_id_d;
    logic [1:0] last_grant_q, last_grant_d;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] strobe;

    assign rise = key_i & ~key_prev_q;

`ifdef KEY_REPEAT_EN
    logic [23:0] hold_cnt_q [4];
    logic [23:0] hold_cnt_d [4];
    logic [3:0]  rep_phase_q, rep_phase_d;

    // The counter restarts from zero after each strobe; rep_phase selects
    // whether the next strobe is the first one (DELAY) or a later one (PERIOD).
    always_comb begin
        strobe      = '0;
        rep_phase_d = rep_phase_q;
        for (int k = 0; k < 4; k++) begin
            hold_cnt_d[k] = hold_cnt_q[k] + 24'd1;
            if (!key_i[k] || rise[k]) begin
                hold_cnt_d[k]  = '0;
                rep_phase_d[k] = 1'b0;
            end else if (hold_cnt_q[k] ==
                         (rep_phase_q[k] ? REPEAT_PERIOD : REPEAT_DELAY) - 24'd1) begin
                strobe[k]      = 1'b1;
                hold_cnt_d[k]  = '0;
                rep_phase_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_phase_q <= '0;
            for (int k = 0; k < 4; k++) begin
                hold_cnt_q[k] <= '0;
            end
        end else begin
            rep_phase_q <= rep_phase_d;
            for (int k = 0; k < 4; k++) begin
                hold_cnt_q[k] <= hold_cnt_d[k];
            end
        end
    end
`else
    logic unused_params;
    assign unused_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign strobe        = '0;
`endif

    // Pending flags, overflow and the two-state offer FSM.
    always_comb begin
        logic       found;
        logic [1:0] idx;

        clr          = '0;
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        found        = 1'b0;
        idx          = '0;

        if (state_q == OFFER && evt_ready) begin
            clr[evt_id_q] = 1'b1;
        end

        // A rise on the key being accepted this cycle re-arms it; a rise on a
        // key that stays pending is lost. Repeat strobes are dropped silently.
        pending_d  = (pending_q & ~clr) | rise | strobe;
        overflow_d = overflow_q | (|(rise & pending_q & ~clr));

        case (state_q)
            IDLE: begin
                // Round-robin search beginning just after the last granted key.
                for (int i = 0; i < 4; i++) begin
                    idx = last_grant_q + 2'(i + 1);
                    if (!found && pending_q[idx]) begin
                        found    = 1'b1;
                        evt_id_d = idx;
                    end
                end
                if (found) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    last_grant_d = evt_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            key_prev_q   <= key_i;   // keys held through reset raise no event
            pending_q    <= '0;
            overflow_q   <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= 2'd3;    // key 0 gets first priority
        end else begin
            state_q      <= state_d;
            key_prev_q   <= key_i;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter. Inputs change and outputs are sampled 1 ns
// after each rising edge; expected values are hand-derived from the behaviour
// of the block (2-edge latency, round-robin order, sticky overflow).
module tb_key_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_i;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  key_arbiter #(
    .REPEAT_DELAY  (24'd10),
    .REPEAT_PERIOD (24'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_i     (key_i),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  // clock
  always #5 clk = ~clk;

  // advance n rising edges, land 1 ns after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_i     = 4'b0000;
    evt_ready = 1'b0;
    step(2);

    // reset state
    chk("rst_valid", {3'b0, evt_valid}, 4'h0);
    chk("rst_id", {2'b0, evt_id}, 4'h0);
    chk("rst_pending", pending, 4'h0);
    chk("rst_overflow", {3'b0, overflow}, 4'h0);

    // single press of key 2, 2-edge latency
    rst       = 1'b0;
    evt_ready = 1'b1;
    key_i     = 4'b0100;
    step(1);
    chk("k2_pending", pending, 4'b0100);
    chk("k2_valid_e0", {3'b0, evt_valid}, 4'h0);
    step(1);
    chk("k2_valid_e1", {3'b0, evt_valid}, 4'h1);
    chk("k2_id", {2'b0, evt_id}, 4'h2);
    step(1);
    chk("k2_valid_after", {3'b0, evt_valid}, 4'h0);
    chk("k2_pending_after", pending, 4'h0);
    key_i = 4'b0000;
    step(2);

    // all four keys at once: order 0,1,2,3 at one event per 2 cycles
    rst = 1'b1;
    step(1);
    rst   = 1'b0;
    key_i = 4'b1111;
    step(1);
    chk("all_pending", pending, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("rr_valid", {3'b0, evt_valid}, 4'h1);
      chk("rr_id", {2'b0, evt_id}, 4'(k));
      step(1);
      chk("rr_gap", {3'b0, evt_valid}, 4'h0);
    end
    chk("rr_drained", pending, 4'h0);
    key_i = 4'b0000;
    step(1);
    key_i = 4'b1111;
    step(1);
    step(1);
    chk("rr2_first_id", {2'b0, evt_id}, 4'h0);
    chk("rr2_first_valid", {3'b0, evt_valid}, 4'h1);
    step(7);
    chk("rr2_drained", pending, 4'h0);
    chk("rr2_idle", {3'b0, evt_valid}, 4'h0);
    key_i = 4'b0000;
    step(1);

    // stall: event held stable, second press overflows
    evt_ready = 1'b0;
    key_i     = 4'b0001;
    step(2);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("stall_valid", {3'b0, evt_valid}, 4'h1);
      chk("stall_id", {2'b0, evt_id}, 4'h0);
    end
    chk("stall_no_ovf", {3'b0, overflow}, 4'h0);
    key_i = 4'b0000;
    step(1);
    key_i = 4'b0001;
    step(1);
    chk("ovf_set", {3'b0, overflow}, 4'h1);
    chk("ovf_valid", {3'b0, evt_valid}, 4'h1);
    step(3);
    chk("ovf_sticky", {3'b0, overflow}, 4'h1);
    rst = 1'b1;
    step(1);
    chk("ovf_rst", {3'b0, overflow}, 4'h0);
    chk("offer_rst_valid", {3'b0, evt_valid}, 4'h0);
    chk("offer_rst_pending", pending, 4'h0);
    rst = 1'b0;
    step(1);

    // key 1 held through reset raises no event
    key_i = 4'b0010;
    rst   = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    chk("held_valid", {3'b0, evt_valid}, 4'h0);
    chk("held_pending", pending, 4'h0);
    key_i = 4'b0000;
    step(1);
    key_i     = 4'b0010;
    evt_ready = 1'b1;
    step(1);
    chk("repress_pending", pending, 4'b0010);
    step(1);
    chk("repress_valid", {3'b0, evt_valid}, 4'h1);
    chk("repress_id", {2'b0, evt_id}, 4'h1);
    step(1);
    chk("repress_done", pending, 4'h0);
    chk("repress_once", {3'b0, evt_valid}, 4'h0);
    step(2);
    chk("repress_no_more", {3'b0, evt_valid}, 4'h0);

    // reset while an event is offered
    key_i     = 4'b0000;
    evt_ready = 1'b0;
    step(1);
    key_i = 4'b1000;
    step(2);
    chk("pre_rst_valid", {3'b0, evt_valid}, 4'h1);
    chk("pre_rst_id", {2'b0, evt_id}, 4'h3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_valid", {3'b0, evt_valid}, 4'h0);
    chk("mid_rst_pending", pending, 4'h0);
    rst   = 1'b0;
    key_i = 4'b0000;
    step(1);

    // accept and new rise of the same key on one edge keep it pending
    key_i = 4'b0100;
    step(2);
    chk("clr_rise_offer", {2'b0, evt_id}, 4'h2);
    key_i = 4'b0000;
    step(1);
    key_i     = 4'b0100;
    evt_ready = 1'b1;
    step(1);
    chk("clr_rise_pending", pending, 4'b0100);
    chk("clr_rise_no_ovf", {3'b0, overflow}, 4'h0);
    chk("clr_rise_gap", {3'b0, evt_valid}, 4'h0);
    step(1);
    chk("clr_rise_reoffer", {3'b0, evt_valid}, 4'h1);
    chk("clr_rise_id", {2'b0, evt_id}, 4'h2);
    step(1);
    chk("clr_rise_done", pending, 4'h0);
    key_i = 4'b0000;
    step(2);

`ifdef KEY_REPEAT_EN
    // key 3 held 30 cycles: offers after press, then every repeat strobe
    evt_ready = 1'b1;
    key_i     = 4'b1000;
    step(1);
    for (int c = 0; c < 40; c++) begin
      logic exp_v;
      exp_v = (c == 1 || c == 11 || c == 15 || c == 19 || c == 23 || c == 27);
      chk("repeat_valid", {3'b0, evt_valid}, {3'b0, exp_v});
      if (c == 29) key_i = 4'b0000;
      step(1);
    end
    chk("repeat_overflow", {3'b0, overflow}, 4'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
